fft_r22sdf_reorder: RTL and testbench
=====================================

FFT_R22SDF_REORDER -- requirements
Module: fft_r22sdf_reorder

Interface
REQ-001 Parameter DW, default 25: sample width per real/imag component.
REQ-002 Parameter N_LOG2, default 10: log2 of FFT length N; SHALL be even.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  clock, rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 valid_i  in  1  input sample qualifier.
REQ-007 sync_i  in  1  first sample of a frame, qualified by valid_i.
REQ-008 x_re_i, x_im_i  in  DW signed each  bit-reversed-order FFT output sample.
REQ-009 valid_o  out  1  output sample qualifier.
REQ-010 start_o  out  1  high with natural-order bin 0.
REQ-011 z_re_o, z_im_o  out  DW signed each  natural-order sample.
REQ-012 idx_o  out  N_LOG2  natural bin index of the current output.
REQ-013 drop_o  out  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-014 Ping-pong storage of 2 banks x N words; write bank and read bank SHALL swap only at frame completion.
REQ-015 Write FSM W_IDLE/W_FILL: W_IDLE->W_FILL on valid_i&sync_i, with that sample at write count 0; valid_i samples in W_IDLE without sync_i are ignored.
REQ-016 In W_FILL each valid_i sample is written at address bitrev(count); count increments only on valid_i; gaps hold count.
REQ-017 At count N-1 with valid_i: frame complete, banks swap, read starts, FSM->W_IDLE.
REQ-018 valid_i&sync_i in W_FILL with count!=0: partial frame discarded, drop_o pulses next cycle, sample written as count 0, stay W_FILL.
REQ-019 Read FSM R_IDLE/R_EMIT: emits addresses 0..N-1 one per cycle, no gaps; valid_o first high 2 cycles after the completing write cycle.
REQ-020 start_o high exactly with idx_o=0; idx_o equals read address; z_* held at last value, valid_o low, when not emitting.
REQ-021 Read of a frame SHALL finish before the next frame completes (input rate <=1/cycle); back-to-back frames SHALL produce gap-free output.
REQ-022 No arithmetic; data passes bit-exact, no width change.

Reset
REQ-023 rst_i: both FSMs to idle, counters and bank pointer 0, valid_o=0, start_o=0, drop_o=0, idx_o=0, z_re_o=z_im_o=0.
REQ-024 Reset mid-frame or mid-read abandons both banks; no output until a new complete frame; RAM contents not cleared.

Configuration
REQ-025 Macro FFT_REORDER_HALF_EN defined: read phase emits bins 0..N/2-1 only (real-input positive spectrum), N/2 valid_o cycles per frame.
REQ-026 Macro undefined: all N bins emitted; ports identical in both cases.

Structure
REQ-027 Package fft_reorder_pkg SHALL hold the bitrev function, default N_LOG2, and FSM state encodings.
REQ-028 Sub-module fft_reorder_ram: simple dual-port, depth 2N (bank bit as address MSB), one-cycle registered read; instantiated once.

Verification (N_LOG2=4, DW=25)
REQ-029 rst_i high 3 cycles with random inputs -> valid_o=0, drop_o=0, z_re_o=z_im_o=0 throughout.
REQ-030 One contiguous frame, bin k presented at input position bitrev(k) with re=k, im=-k -> 16 consecutive valid_o, z_re_o=0..15, z_im_o=0..-15, start_o on first, first valid_o 2 cycles after last input.
REQ-031 Same frame with valid_i every other cycle -> identical output, 16 contiguous valid_o cycles.
REQ-032 sync_i reasserted at input count 5 -> drop_o single pulse, no output for partial frame, following full frame output correct.
REQ-033 Frames A (re=k) and B (re=100+k) back-to-back -> 32 contiguous valid_o cycles, A then B, start_o at both bin 0s.
REQ-034 FFT_REORDER_HALF_EN defined, scenario of REQ-030 -> 8 valid_o cycles, z_re_o=0..7, then valid_o low.

Source files
------------

// File: rtl/fft_reorder_pkg.sv
// Shared definitions for the bit-reversed to natural-order FFT reorder buffer:
// default FFT size, FSM state encodings and the bit-reversal helper.
package fft_reorder_pkg;

    localparam int DEFAULT_N_LOG2 = 10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_EMIT = 1'b1
    } rd_state_e;

    // Reverses the low nbits of v; bits above nbits come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int nbits);
        logic [31:0] r;
        logic [31:0] s;
        r = '0;
        s = v;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r = {r[30:0], s[0]};
                s = s >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port storage for the reorder buffer: one write port, one read
// port with a single registered read stage that holds its value when idle.
module fft_reorder_ram #(
    parameter int DW = 50,
    parameter int AW = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    always_comb begin
        rdata_d = re_i ? mem[raddr_i] : rdata_q;
    end

    // NOTE: the array has no reset so it maps onto block RAM; only the read
    // register is cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_r22sdf_reorder.sv
// Ping-pong reorder buffer turning bit-reversed FFT output into natural order.
// Define FFT_REORDER_HALF_EN to emit only bins 0..N/2-1 of each frame.
module fft_r22sdf_reorder
    import fft_reorder_pkg::*;
#(
    parameter int DW     = 25,
    parameter int N_LOG2 = DEFAULT_N_LOG2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic                 sync_i,
    input  logic signed [DW-1:0] x_re_i,
    input  logic signed [DW-1:0] x_im_i,
    output logic                 valid_o,
    output logic                 start_o,
    output logic signed [DW-1:0] z_re_o,
    output logic signed [DW-1:0] z_im_o,
    output logic [N_LOG2-1:0]    idx_o,
    output logic                 drop_o
);

    localparam int N = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] WR_LAST = N_LOG2'(N - 1);
`ifdef FFT_REORDER_HALF_EN
    localparam logic [N_LOG2-1:0] RD_LAST = N_LOG2'(N / 2 - 1);
`else
    localparam logic [N_LOG2-1:0] RD_LAST = N_LOG2'(N - 1);
`endif

    wr_state_e           wr_state_q, wr_state_d;
    logic [N_LOG2-1:0]   wr_cnt_q, wr_cnt_d;
    logic                wr_bank_q, wr_bank_d;
    logic                drop_q, drop_d;

    rd_state_e           rd_state_q, rd_state_d;
    logic [N_LOG2-1:0]   rd_cnt_q, rd_cnt_d;
    logic                rd_bank_q, rd_bank_d;

    logic                valid_q, valid_d;
    logic                start_q, start_d;
    logic [N_LOG2-1:0]   idx_q, idx_d;

    logic                ram_we;
    logic [N_LOG2:0]     ram_waddr;
    logic                ram_re;
    logic [N_LOG2:0]     ram_raddr;
    logic [2*DW-1:0]     ram_rdata;
    logic                frame_done;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        drop_d     = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = {wr_bank_q, N_LOG2'(bitrev(32'(wr_cnt_q), N_LOG2))};
        frame_done = 1'b0;

        case (wr_state_q)
            W_IDLE: begin
                if (valid_i && sync_i) begin
                    ram_we     = 1'b1;
                    ram_waddr  = {wr_bank_q, {N_LOG2{1'b0}}};
                    wr_cnt_d   = N_LOG2'(1);
                    wr_state_d = W_FILL;
                end
            end
            W_FILL: begin
                if (valid_i) begin
                    ram_we = 1'b1;
                    if (sync_i && wr_cnt_q != '0) begin
                        // Early sync: restart the frame in the same bank.
                        drop_d    = 1'b1;
                        ram_waddr = {wr_bank_q, {N_LOG2{1'b0}}};
                        wr_cnt_d  = N_LOG2'(1);
                    end else if (wr_cnt_q == WR_LAST) begin
                        frame_done = 1'b1;
                        wr_bank_d  = ~wr_bank_q;
                        wr_cnt_d   = '0;
                        wr_state_d = W_IDLE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_bank_d  = rd_bank_q;
        ram_re     = (rd_state_q == R_EMIT);
        ram_raddr  = {rd_bank_q, rd_cnt_q};

        if (rd_state_q == R_EMIT) begin
            if (rd_cnt_q == RD_LAST) begin
                rd_state_d = R_IDLE;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end
        // A completed frame always (re)starts the read on the bank just filled.
        if (frame_done) begin
            rd_state_d = R_EMIT;
            rd_cnt_d   = '0;
            rd_bank_d  = wr_bank_q;
        end

        valid_d = ram_re;
        start_d = ram_re && (rd_cnt_q == '0);
        idx_d   = ram_re ? rd_cnt_q : idx_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            drop_q     <= 1'b0;
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
            rd_bank_q  <= 1'b0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            idx_q      <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_bank_q  <= wr_bank_d;
            drop_q     <= drop_d;
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_bank_q  <= rd_bank_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            idx_q      <= idx_d;
        end
    end

    fft_reorder_ram #(
        .DW (2 * DW),
        .AW (N_LOG2 + 1)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i ({x_re_i, x_im_i}),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign valid_o = valid_q;
    assign start_o = start_q;
    assign idx_o   = idx_q;
    assign drop_o  = drop_q;
    assign z_re_o  = ram_rdata[2*DW-1:DW];
    assign z_im_o  = ram_rdata[DW-1:0];

endmodule

// File: tb/tb_fft_r22sdf_reorder.sv
// Scoreboard bench for fft_r22sdf_reorder at N_LOG2=4, DW=25; follows the
// FFT_REORDER_HALF_EN macro to expect half or full frames.
module tb_fft_r22sdf_reorder;

    localparam int DW     = 25;
    localparam int N_LOG2 = 4;
    localparam int N      = 1 << N_LOG2;
`ifdef FFT_REORDER_HALF_EN
    localparam int  NOUT = N / 2;
    localparam bit  HALF = 1'b1;
`else
    localparam int  NOUT = N;
    localparam bit  HALF = 1'b0;
`endif

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic [N_LOG2-1:0]    idx;
        logic                 start;
    } exp_t;

    logic                 clk;
    logic                 rst_i;
    logic                 valid_i;
    logic                 sync_i;
    logic signed [DW-1:0] x_re_i;
    logic signed [DW-1:0] x_im_i;
    logic                 valid_o;
    logic                 start_o;
    logic signed [DW-1:0] z_re_o;
    logic signed [DW-1:0] z_im_o;
    logic [N_LOG2-1:0]    idx_o;
    logic                 drop_o;

    exp_t sb_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   mon_en     = 1'b0;
    bit   mon_prev   = 1'b0;
    int   mon_valid  = 0;
    int   mon_runs   = 0;
    int   mon_drops  = 0;
    int   mon_starts = 0;

    fft_r22sdf_reorder #(
        .DW     (DW),
        .N_LOG2 (N_LOG2)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .sync_i  (sync_i),
        .x_re_i  (x_re_i),
        .x_im_i  (x_im_i),
        .valid_o (valid_o),
        .start_o (start_o),
        .z_re_o  (z_re_o),
        .z_im_o  (z_im_o),
        .idx_o   (idx_o),
        .drop_o  (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int tb_bitrev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < N_LOG2; b++) begin
            if ((v >> b) & 1) r = r | (1 << (N_LOG2 - 1 - b));
        end
        return r;
    endfunction

    // Output monitor: every valid_o cycle pops one expected bin.
    always @(negedge clk) begin
        if (mon_en && !rst_i) begin
            if (drop_o) mon_drops++;
            if (valid_o) begin
                exp_t e;
                mon_valid++;
                if (!mon_prev) mon_runs++;
                if (start_o) mon_starts++;
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output got re=%0d im=%0d idx=%0d, required no valid_o",
                             z_re_o, z_im_o, idx_o);
                end else begin
                    e = sb_q.pop_front();
                    if (z_re_o !== e.re || z_im_o !== e.im || idx_o !== e.idx || start_o !== e.start) begin
                        miscompares++;
                        $display("FAIL bin_data got re=%0d im=%0d idx=%0d start=%0b, required re=%0d im=%0d idx=%0d start=%0b",
                                 z_re_o, z_im_o, idx_o, start_o, e.re, e.im, e.idx, e.start);
                    end
                end
            end
            mon_prev = valid_o;
        end
    end

    task automatic clear_stats();
        mon_prev   = 1'b0;
        mon_valid  = 0;
        mon_runs   = 0;
        mon_drops  = 0;
        mon_starts = 0;
    endtask

    task automatic idle_input();
        @(negedge clk);
        valid_i = 1'b0;
        sync_i  = 1'b0;
        x_re_i  = DW'($urandom);
        x_im_i  = DW'($urandom);
    endtask

    // Drives one frame in bit-reversed order: position p carries bin bitrev(p).
    task automatic send_frame(input int base, input int gap, input bit expect_drop);
        for (int p = 0; p < N; p++) begin
            int k;
            k = tb_bitrev(p);
            @(negedge clk);
            if (expect_drop && p == 1) begin
                vectors++;
                if (drop_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL drop_pulse got %0b required 1", drop_o);
                end
            end
            if (expect_drop && p == 2) begin
                vectors++;
                if (drop_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL drop_single got %0b required 0", drop_o);
                end
            end
            valid_i = 1'b1;
            sync_i  = (p == 0);
            x_re_i  = DW'(base + k);
            x_im_i  = DW'(-(base + k));
            if (p < N - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    valid_i = 1'b0;
                    sync_i  = 1'b0;
                    x_re_i  = DW'($urandom);
                    x_im_i  = DW'($urandom);
                end
            end
        end
        for (int k = 0; k < NOUT; k++) begin
            exp_t e;
            e.re    = DW'(base + k);
            e.im    = DW'(-(base + k));
            e.idx   = N_LOG2'(k);
            e.start = (k == 0);
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0 && !valid_o) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain got %0d bins outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_counts(input string name, input int valid_exp, input int runs_exp,
                                input int drops_exp);
        vectors++;
        if (mon_valid != valid_exp || mon_runs != runs_exp || mon_drops != drops_exp) begin
            miscompares++;
            $display("FAIL %s_counts got valid=%0d runs=%0d drops=%0d, required valid=%0d runs=%0d drops=%0d",
                     name, mon_valid, mon_runs, mon_drops, valid_exp, runs_exp, drops_exp);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            valid_i = 1'($urandom);
            sync_i  = 1'($urandom);
            x_re_i  = DW'($urandom);
            x_im_i  = DW'($urandom);
            vectors++;
            if (valid_o !== 1'b0 || drop_o !== 1'b0 || start_o !== 1'b0 ||
                z_re_o !== '0 || z_im_o !== '0 || idx_o !== '0) begin
                miscompares++;
                $display("FAIL reset_state cycle %0d got valid=%0b drop=%0b start=%0b re=%0d im=%0d idx=%0d, required all 0",
                         c, valid_o, drop_o, start_o, z_re_o, z_im_o, idx_o);
            end
        end
        @(negedge clk);
        rst_i   = 1'b0;
        valid_i = 1'b0;
        sync_i  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contiguous();
        clear_stats();
        send_frame(0, 0, 1'b0);
        @(negedge clk);
        valid_i = 1'b0;
        sync_i  = 1'b0;
        vectors++;
        if (valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early got valid_o=%0b required 0", valid_o);
        end
        @(negedge clk);
        vectors++;
        if (valid_o !== 1'b1 || start_o !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_first got valid_o=%0b start_o=%0b required 1 1", valid_o, start_o);
        end
        drain("contiguous");
        check_counts("contiguous", NOUT, 1, 0);
    endtask

    task automatic test_gapped();
        clear_stats();
        send_frame(0, 1, 1'b0);
        idle_input();
        drain("gapped");
        check_counts("gapped", NOUT, 1, 0);
    endtask

    task automatic test_drop();
        clear_stats();
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            valid_i = 1'b1;
            sync_i  = (p == 0);
            x_re_i  = DW'(50 + p);
            x_im_i  = DW'(-(50 + p));
        end
        send_frame(0, 0, 1'b1);
        idle_input();
        drain("drop");
        check_counts("drop", NOUT, 1, 1);
    endtask

    task automatic test_reset_mid_frame();
        clear_stats();
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            valid_i = 1'b1;
            sync_i  = (p == 0);
            x_re_i  = DW'(70 + p);
            x_im_i  = DW'(p);
        end
        @(negedge clk);
        valid_i = 1'b0;
        sync_i  = 1'b0;
        rst_i   = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            valid_i = 1'b1;
            sync_i  = 1'b0;
        end
        idle_input();
        repeat (4) @(negedge clk);
        check_counts("reset_abandon", 0, 0, 0);
        send_frame(200, 0, 1'b0);
        idle_input();
        drain("reset_recover");
        check_counts("reset_recover", NOUT, 1, 0);
    endtask

    task automatic test_back_to_back();
        clear_stats();
        send_frame(0, 0, 1'b0);
        send_frame(100, 0, 1'b0);
        idle_input();
        drain("back_to_back");
        check_counts("back_to_back", 2 * NOUT, HALF ? 2 : 1, 0);
        vectors++;
        if (mon_starts != 2) begin
            miscompares++;
            $display("FAIL back_to_back_starts got %0d required 2", mon_starts);
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        sync_i  = 1'b0;
        x_re_i  = '0;
        x_im_i  = '0;
        test_reset();
        mon_en = 1'b1;
        test_contiguous();
        test_gapped();
        test_drop();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
